regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 8, bits per register.
  ADDR_W, 3, address bits; DEPTH = 2**ADDR_W registers.
  NUM_RD, 2, read port count (>=1).
  R0_ZERO, 0, 1 = register 0 hardwired to zero.
  BYPASS, 1, 1 = same-cycle write-to-read forwarding.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all state updates on rising edge.
  rst  in  1  asynchronous, active-high reset.
  we0  in  1  write enable, port 0.
  waddr0  in  ADDR_W  write address, port 0.
  wdata0  in  DATA_W  write data, port 0.
  we1  in  1  write enable, port 1.
  waddr1  in  ADDR_W  write address, port 1.
  wdata1  in  DATA_W  write data, port 1.
  rsv_en  in  1  reserve (mark busy) request.
  rsv_addr  in  ADDR_W  register to reserve.
  raddr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
  rdata  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
  rbusy  out  NUM_RD  busy flag of each read port's addressed register.
  wr_conflict  out  1  registered pulse: both write ports hit the same address.
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 Storage SHALL be DEPTH x DATA_W registers plus one busy bit per register.
REQ-005 Writes SHALL commit on the clk rising edge when the port's enable is high.
REQ-006 When we0 and we1 are both high with waddr0 == waddr1, only wdata1 SHALL be stored (port 1 wins).
REQ-007 wr_conflict SHALL be 1 for exactly the cycle after an edge at which we0 & we1 & (waddr0 == waddr1), otherwise 0.
REQ-008 Reads SHALL be combinational, zero-latency; each rdata slice SHALL show the stored value at its raddr.
REQ-009 With BYPASS=1, a read of an address being written this cycle SHALL return the incoming data (wdata1 over wdata0 when both match); with BYPASS=0 it SHALL return the pre-edge stored value.
REQ-010 With R0_ZERO=1, reads of address 0 SHALL return 0, writes to address 0 SHALL be ignored, and register 0 SHALL never be busy (rsv_en to 0 ignored, rbusy 0, no bypass).
REQ-011 rsv_en SHALL set busy[rsv_addr] at the next rising edge.
REQ-012 A write (either port) SHALL clear the busy bit of its address at the same edge.
REQ-013 If rsv_en and a write target the same address at the same edge, the data SHALL be written and busy SHALL end set (the reservation names a newer producer).
REQ-014 rbusy[k] SHALL equal busy[raddr_k]; with BYPASS=1 it SHALL be 0 while a write to raddr_k is present in the same cycle; with BYPASS=0 it SHALL ignore same-cycle writes.
REQ-015 Writes to a register that is not busy SHALL still be accepted; busy is advisory only.
REQ-016 Out-of-range addresses are impossible by construction (DEPTH = 2**ADDR_W); no wrap handling is required.

Reset
REQ-017 While rst is high, all registers SHALL be 0, all busy bits 0, wr_conflict 0, and writes and reservations SHALL be ignored.
REQ-018 Reset asserted mid-operation SHALL clear state immediately, without waiting for clk; the first post-reset edge SHALL behave as a normal cycle.
REQ-019 After reset, all rdata SHALL read 0 and all rbusy 0.

Verification
REQ-020 Default params: reset; write reg3=0xA5 via port 0; next cycle raddr port0=3 -> rdata port0=0xA5, rbusy=0.
REQ-021 we0 (addr 5, 0x11) and we1 (addr 5, 0x22) at the same edge -> reg5=0x22, wr_conflict=1 for one cycle then 0.
REQ-022 BYPASS=1: we1 addr 2 data 0x7E while raddr=2 in the same cycle -> rdata=0x7E before the edge; BYPASS=0 -> old value until after the edge.
REQ-023 rsv_en addr 4 -> next cycle rbusy=1 for raddr=4; write 0x33 to 4 -> rbusy=0 after the edge; reserve and write addr 4 at the same edge -> data 0x33 and rbusy=1.
REQ-024 R0_ZERO=1: write 0xFF to addr 0 and rsv_en addr 0 -> rdata=0, rbusy=0.
REQ-025 After filling regs with non-zero values and busy bits, assert rst between clk edges -> all rdata=0, rbusy=0, wr_conflict=0 immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with per-register busy
// (reservation) bits.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   we0/waddr0/wdata0, we1/waddr1/wdata1
//                two write ports; port 1 wins on an address collision
//   rsv_en/rsv_addr
//                mark a register busy at the next edge
//   raddr        NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata        NUM_RD packed read data,      port k at [k*DATA_W +: DATA_W]
//   rbusy        busy flag of each read port's addressed register
//   wr_conflict  registered pulse: both write ports hit the same address
module regfile_mp #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_conflict_q;
  logic              wr_conflict_d;

  logic              wr0_ok;
  logic              wr1_ok;
  logic              rsv_ok;
  logic [ADDR_W-1:0] ra;

  // Qualified requests: register 0 is untouchable when hardwired, and
  // nothing may leak through the bypass path while reset is held.
  always_comb begin
    wr0_ok = we0    & ~rst & ~((R0_ZERO != 0) && (waddr0   == '0));
    wr1_ok = we1    & ~rst & ~((R0_ZERO != 0) && (waddr1   == '0));
    rsv_ok = rsv_en & ~rst & ~((R0_ZERO != 0) && (rsv_addr == '0));
  end

  // Ordering gives the priorities: port 1 overrides port 0, and a
  // reservation overrides the busy-clear of a write to the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[waddr0] = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[waddr1] = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    wr_conflict_d = we0 & we1 & (waddr0 == waddr1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q        <= '{default: '0};
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      rdata[k*DATA_W +: DATA_W] = regs_q[ra];
      rbusy[k]                  = busy_q[ra];
      if (BYPASS != 0) begin
        if (wr0_ok && (waddr0 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata0;
          rbusy[k]                  = 1'b0;
        end
        if (wr1_ok && (waddr1 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata1;
          rbusy[k]                  = 1'b0;
        end
      end
      if ((R0_ZERO != 0) && (ra == '0)) begin
        rdata[k*DATA_W +: DATA_W] = '0;
        rbusy[k]                  = 1'b0;
      end
    end
  end

endmodule
